// File: rtl/set_assoc_wb_cache_pkg.sv
// set_assoc_wb_cache_pkg: FSM state type and address-field width helpers shared by the cache.
package set_assoc_wb_cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  function automatic int bits_of(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/set_assoc_wb_cache_if.sv
// set_assoc_wb_cache_if: CPU-side and block-wide memory-side buses of the cache.
interface set_assoc_wb_cache_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_WORDS = 4
);
  logic                             cpu_req, cpu_we, cpu_ready, stall_pc;
  logic                             mem_req, mem_we, mem_ready;
  logic [ADDR_WIDTH-1:0]            cpu_addr, mem_addr;
  logic [WORD_SIZE-1:0]             cpu_wdata, cpu_rdata;
  logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready, stall_pc, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready, stall_pc, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_wb_cache_lru_set.sv
// cache_lru_set: per-set LRU ages (0 = most recent); reports the oldest way of the addressed set.
module cache_lru_set
  import set_assoc_wb_cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [width_of(NUM_SETS)-1:0] i_set,
  input  logic [width_of(NUM_WAYS)-1:0] i_way,
  input  logic                          i_upd,
  output logic [width_of(NUM_WAYS)-1:0] o_victim
);
  localparam int WW = width_of(NUM_WAYS);
  if (NUM_WAYS == 1) begin : g_one
    assign o_victim = '0;
  end else begin : g_lru
    logic [WW-1:0] r_age [NUM_SETS][NUM_WAYS];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < NUM_SETS; s++)
          for (int w = 0; w < NUM_WAYS; w++) r_age[s][w] <= WW'(w);
      end else if (i_upd) begin
        for (int w = 0; w < NUM_WAYS; w++)
          r_age[i_set][w] <= (WW'(w) == i_way) ? '0 :
                             (r_age[i_set][w] < r_age[i_set][i_way]) ? r_age[i_set][w] + 1'b1 :
                             r_age[i_set][w];
      end
    end
    always_comb begin
      o_victim = '0;
      for (int w = 0; w < NUM_WAYS; w++)
        if (r_age[i_set][w] == WW'(NUM_WAYS - 1)) o_victim = WW'(w);
    end
  end
endmodule

// File: rtl/set_assoc_wb_cache.sv
// set_assoc_wb_cache: N-way set-associative write-back/write-allocate data cache with LRU
// replacement; one request in flight, stall_pc held until the completion pulse.
module set_assoc_wb_cache
  import set_assoc_wb_cache_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int NUM_SETS    = 4,
  parameter int NUM_WAYS    = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input logic                clk,
  input logic                reset_n,
  set_assoc_wb_cache_if.slave bus
);
  localparam int BO  = bits_of(WORD_SIZE / 8);
  localparam int WO  = bits_of(BLOCK_WORDS);
  localparam int IW  = bits_of(NUM_SETS);
  localparam int OW  = BO + WO;
  localparam int TW  = ADDR_WIDTH - OW - IW;
  localparam int LW  = WORD_SIZE * BLOCK_WORDS;
  localparam int WW  = width_of(NUM_WAYS);
  localparam int WOW = width_of(BLOCK_WORDS);
  state_t                r_state, w_next;
  logic                  r_we;
  logic [TW-1:0]         r_ctag;
  logic [IW-1:0]         r_idx;
  logic [WOW-1:0]        r_woff, w_woff;
  logic [WORD_SIZE-1:0]  r_wdata, r_rdata, w_word;
  logic [WW-1:0]         r_way, w_hit_way, w_victim, w_lru_victim, w_way;
  logic [TW-1:0]         r_tag   [NUM_SETS][NUM_WAYS];
  logic [LW-1:0]         r_data  [NUM_SETS][NUM_WAYS];
  logic                  r_valid [NUM_SETS][NUM_WAYS];
  logic                  r_dirty [NUM_SETS][NUM_WAYS];
  logic                  w_hit, w_fill, w_wr, w_upd;
  logic [LW-1:0]         w_src, w_line;
  if (BLOCK_WORDS > 1) begin : g_woff
    assign w_woff = bus.cpu_addr[BO +: WOW];
  end else begin : g_no_woff
    assign w_woff = '0;
  end
  if (BO > 0) begin : g_byte_off
    logic w_unused_byte_off;
    assign w_unused_byte_off = ^bus.cpu_addr[BO-1:0];
  end
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = w_lru_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[r_idx][w] && r_tag[r_idx][w] == r_ctag) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
      if (!r_valid[r_idx][w]) w_victim = WW'(w);
    end
  end
  assign w_way  = (r_state == REFILL) ? r_way : w_hit_way;
  assign w_fill = (r_state == REFILL) && bus.mem_ready;
  assign w_upd  = w_fill || (r_state == LOOKUP && w_hit);
  assign w_wr   = w_fill || (r_state == LOOKUP && w_hit && r_we);
  assign w_src  = (r_state == REFILL) ? bus.mem_rdata : r_data[r_idx][w_hit_way];
  assign w_word = w_src[int'(r_woff) * WORD_SIZE +: WORD_SIZE];
  // Store data is merged into the line on its way into the array, for hits and refills alike
  always_comb begin
    w_line = w_src;
    if (r_we) w_line[int'(r_woff) * WORD_SIZE +: WORD_SIZE] = r_wdata;
  end
  cache_lru_set #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
    .clk(clk), .reset_n(reset_n), .i_set(r_idx), .i_way(w_way), .i_upd(w_upd), .o_victim(w_lru_victim)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = bus.cpu_req ? LOOKUP : IDLE;
      LOOKUP:    w_next = w_hit ? RESPOND : (r_valid[r_idx][w_victim] && r_dirty[r_idx][w_victim]) ? WRITEBACK : REFILL;
      WRITEBACK: w_next = bus.mem_ready ? REFILL : WRITEBACK;
      REFILL:    w_next = bus.mem_ready ? RESPOND : REFILL;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.mem_req   = (r_state == WRITEBACK) || (r_state == REFILL);
    bus.mem_we    = r_state == WRITEBACK;
    bus.mem_addr  = (r_state == WRITEBACK) ? ADDR_WIDTH'({r_tag[r_idx][r_way], r_idx}) << OW :
                    (r_state == REFILL) ? ADDR_WIDTH'({r_ctag, r_idx}) << OW : '0;
    bus.mem_wdata = (r_state == WRITEBACK) ? r_data[r_idx][r_way] : '0;
    bus.cpu_ready = r_state == RESPOND;
    bus.stall_pc  = r_state inside {LOOKUP, WRITEBACK, REFILL};
    bus.cpu_rdata = r_rdata;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_ctag  <= '0;
      r_idx   <= '0;
      r_woff  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_way   <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
    end else begin
      if (r_state == IDLE && bus.cpu_req) begin
        r_we    <= bus.cpu_we;
        r_ctag  <= bus.cpu_addr[ADDR_WIDTH-1 -: TW];
        r_idx   <= bus.cpu_addr[OW +: IW];
        r_woff  <= w_woff;
        r_wdata <= bus.cpu_wdata;
      end
      if (r_state == LOOKUP) r_way <= w_hit ? w_hit_way : w_victim;
      if (w_upd && !r_we) r_rdata <= w_word;
      if (w_wr) begin
        r_valid[r_idx][w_way] <= 1'b1;
        r_dirty[r_idx][w_way] <= r_we;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_data[r_idx][w_way] <= w_line;
    if (w_fill) r_tag[r_idx][w_way] <= r_ctag;
  end
endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// tb_set_assoc_wb_cache: directed vector table, reset corner case, and random traffic
// checked against a recency-list cache model backed by a sparse memory.
module tb_set_assoc_wb_cache;
  localparam int WS = 32, BW = 4, NS = 4, NW = 2, AW = 32;
  localparam int LW = WS * BW, LB = BW * WS / 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  set_assoc_wb_cache_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .BLOCK_WORDS(BW)) bus ();
  set_assoc_wb_cache #(.WORD_SIZE(WS), .BLOCK_WORDS(BW), .NUM_SETS(NS), .NUM_WAYS(NW), .ADDR_WIDTH(AW))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int n_chk = 0, n_fail = 0;
  logic [LW-1:0] mem [logic [31:0]];
  int tx_n, lat, mem_cyc;
  logic tx_we [2];
  logic [31:0] tx_addr [2];
  logic [LW-1:0] tx_data [2];
  logic [31:0] got_rdata;
  bit stall_ok, tmo;
  typedef struct {
    logic we; logic [31:0] addr, wdata; int ntx;
    logic [31:0] wb_addr, wb_w1, ref_addr, rdata;
  } vec_t;
  vec_t vt [16];
  typedef struct { int unsigned set, tag; logic [LW-1:0] data; bit dirty; } ent_t;
  ent_t cq [$];
  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [LW-1:0] mem_get(input logic [31:0] a);
    if (!mem.exists(a)) begin
      logic [LW-1:0] l;
      for (int w = 0; w < BW; w++) l[w*WS +: WS] = $urandom;
      mem[a] = l;
    end
    return mem[a];
  endfunction
  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA5A5_0000 + a - 32'h10;
  endfunction
  // One CPU request; acts as the memory with random 0..2 cycle acknowledge delay
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d);
    int dly, cur;
    tx_n = 0; mem_cyc = 0; stall_ok = 1; tmo = 0;
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_req = 0;
    lat = 1;
    cur = $urandom_range(0, 2); dly = cur;
    forever begin
      bus.mem_ready = 0;
      if (bus.cpu_ready) break;
      if (!bus.stall_pc) stall_ok = 0;
      if (bus.mem_req) begin
        if (dly == 0) begin
          if (tx_n < 2) begin
            tx_we[tx_n] = bus.mem_we; tx_addr[tx_n] = bus.mem_addr; tx_data[tx_n] = bus.mem_wdata;
          end
          tx_n++;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_get(bus.mem_addr);
          bus.mem_ready = 1;
          mem_cyc += cur + 1;
          cur = $urandom_range(0, 2); dly = cur;
        end else dly--;
      end
      if (lat >= 60) begin tmo = 1; break; end
      @(negedge clk);
      lat++;
    end
    if (bus.stall_pc) stall_ok = 0;
    got_rdata = bus.cpu_rdata;
    check("timeout", tmo, 0);
    check("stall_pc", stall_ok, 1);
    check("latency", lat, 2 + mem_cyc);
    @(negedge clk);
  endtask
  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    int unsigned set, tag, wi, cnt;
    int hit_i, last, exp_n;
    logic [31:0] laddr, exp_rd;
    logic exp_we [2];
    logic [31:0] exp_addr [2];
    logic [LW-1:0] exp_data [2];
    ent_t e, v;
    set = (a / LB) % NS; tag = a / (LB * NS); laddr = a - a % LB; wi = (a % LB) / (WS / 8);
    hit_i = -1; last = -1; cnt = 0; exp_n = 0;
    foreach (cq[i]) if (cq[i].set == set) begin
      cnt++; last = i;
      if (cq[i].tag == tag) hit_i = i;
    end
    if (hit_i >= 0) begin
      e = cq[hit_i]; cq.delete(hit_i);
    end else begin
      if (cnt == NW) begin
        v = cq[last]; cq.delete(last);
        if (v.dirty) begin
          exp_we[0] = 1; exp_addr[0] = (v.tag * NS + v.set) * LB; exp_data[0] = v.data; exp_n = 1;
        end
      end
      e.set = set; e.tag = tag; e.dirty = 0; e.data = mem_get(laddr);
      exp_we[exp_n] = 0; exp_addr[exp_n] = laddr; exp_data[exp_n] = '0; exp_n++;
    end
    exp_rd = e.data[wi*WS +: WS];
    if (we) begin e.data[wi*WS +: WS] = d; e.dirty = 1; end
    cq.push_front(e);
    access(we, a, d);
    check("rnd_ntx", tx_n, exp_n);
    for (int i = 0; i < exp_n && i < tx_n; i++) begin
      check("rnd_mem_we", tx_we[i], exp_we[i]);
      check("rnd_mem_addr", tx_addr[i], exp_addr[i]);
      if (exp_we[i]) check("rnd_wb_line", tx_data[i], exp_data[i]);
    end
    if (!we) check("rnd_rdata", got_rdata, exp_rd);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{0, 32'h10,  32'h0,        1, 32'h0,   32'h0,        32'h10,  32'hA5A5_0000};
    vt[1]  = '{0, 32'h10,  32'h0,        0, 32'h0,   32'h0,        32'h0,   32'hA5A5_0000};
    vt[2]  = '{1, 32'h14,  32'hDEADBEEF, 0, 32'h0,   32'h0,        32'h0,   32'h0};
    vt[3]  = '{0, 32'h14,  32'h0,        0, 32'h0,   32'h0,        32'h0,   32'hDEADBEEF};
    vt[4]  = '{0, 32'h50,  32'h0,        1, 32'h0,   32'h0,        32'h50,  32'hA5A5_0040};
    vt[5]  = '{0, 32'h94,  32'h0,        2, 32'h10,  32'hDEADBEEF, 32'h90,  32'hA5A5_0084};
    vt[6]  = '{0, 32'h50,  32'h0,        0, 32'h0,   32'h0,        32'h0,   32'hA5A5_0040};
    vt[7]  = '{0, 32'hD0,  32'h0,        1, 32'h0,   32'h0,        32'hD0,  32'hA5A5_00C0};
    vt[8]  = '{0, 32'h50,  32'h0,        0, 32'h0,   32'h0,        32'h0,   32'hA5A5_0040};
    vt[9]  = '{0, 32'h98,  32'h0,        1, 32'h0,   32'h0,        32'h90,  32'hA5A5_0088};
    vt[10] = '{1, 32'h114, 32'h12345678, 1, 32'h0,   32'h0,        32'h110, 32'h0};
    vt[11] = '{0, 32'h50,  32'h0,        1, 32'h0,   32'h0,        32'h50,  32'hA5A5_0040};
    vt[12] = '{0, 32'hD4,  32'h0,        2, 32'h110, 32'h12345678, 32'hD0,  32'hA5A5_00C4};
    vt[13] = '{0, 32'h114, 32'h0,        1, 32'h0,   32'h0,        32'h110, 32'h12345678};
    vt[14] = '{0, 32'h20,  32'h0,        1, 32'h0,   32'h0,        32'h20,  32'hA5A5_0010};
    vt[15] = '{0, 32'hD0,  32'h0,        0, 32'h0,   32'h0,        32'h0,   32'hA5A5_00C0};
    foreach (vt[i]) begin
      logic [31:0] l;
      logic [LW-1:0] line;
      l = vt[i].addr - vt[i].addr % LB;
      for (int w = 0; w < BW; w++) line[w*WS +: WS] = pat(l + 32'(4 * w));
      if (!mem.exists(l)) mem[l] = line;
    end
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    #12;
    check("rst_cpu_ready", bus.cpu_ready, 0);
    check("rst_stall_pc", bus.stall_pc, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    @(negedge clk); reset_n = 1; @(negedge clk);
    foreach (vt[i]) begin
      access(vt[i].we, vt[i].addr, vt[i].wdata);
      check($sformatf("v%0d_ntx", i), tx_n, vt[i].ntx);
      if (vt[i].ntx == 0) check($sformatf("v%0d_hit_lat", i), lat, 2);
      if (vt[i].ntx == 1 && tx_n == 1) begin
        check($sformatf("v%0d_ref_we", i), tx_we[0], 0);
        check($sformatf("v%0d_ref_addr", i), tx_addr[0], vt[i].ref_addr);
      end
      if (vt[i].ntx == 2 && tx_n == 2) begin
        check($sformatf("v%0d_wb_we", i), tx_we[0], 1);
        check($sformatf("v%0d_wb_addr", i), tx_addr[0], vt[i].wb_addr);
        check($sformatf("v%0d_wb_w1", i), tx_data[0][WS +: WS], vt[i].wb_w1);
        check($sformatf("v%0d_ref_addr", i), tx_addr[1], vt[i].ref_addr);
      end
      if (!vt[i].we) check($sformatf("v%0d_rdata", i), got_rdata, vt[i].rdata);
    end
    // Reset arriving while a refill is outstanding
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h190;
    @(negedge clk);
    bus.cpu_req = 0;
    for (int i = 0; i < 10 && !bus.mem_req; i++) @(negedge clk);
    check("rst_mid_mem_req_pre", bus.mem_req, 1);
    check("rst_mid_mem_we_pre", bus.mem_we, 0);
    reset_n = 0;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_stall_pc", bus.stall_pc, 0);
    check("rst_mid_cpu_ready", bus.cpu_ready, 0);
    @(negedge clk); reset_n = 1; @(negedge clk);
    access(0, 32'hD0, 0);
    check("post_rst_ntx", tx_n, 1);
    check("post_rst_rdata", got_rdata, 32'hA5A5_00C0);
    reset_n = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      int unsigned tg, ix, wd;
      tg = $urandom_range(0, 5); ix = $urandom_range(0, NS - 1); wd = $urandom_range(0, BW - 1);
      model_access(1'($urandom_range(0, 1)), 32'(((tg * NS + ix) * BW + wd) * 4), $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
